// File: rtl/neo_pkg.sv
// neo_pkg: shared constants and types for the LSPC timer / interrupt logic.
//   - LSPCMODE_*  : DIN bit positions of the mode-register fields
//   - MODE_*      : the same fields as indices into the stored 4-bit MODE
//   - ACK_*       : DIN bit positions of the interrupt acknowledge bits
//   - IRQ_LVL_*   : 68k interrupt levels presented on IRQ_LEVEL
package neo_pkg;

  localparam int LSPCMODE_TMR_EN   = 4;
  localparam int LSPCMODE_RLD_WR   = 5;
  localparam int LSPCMODE_RLD_VBL  = 6;
  localparam int LSPCMODE_RLD_ZERO = 7;

  // MODE is stored as DIN[7:4], so field indices are offset by the LSB
  localparam int MODE_LSB      = LSPCMODE_TMR_EN;
  localparam int MODE_TMR_EN   = LSPCMODE_TMR_EN   - MODE_LSB;
  localparam int MODE_RLD_WR   = LSPCMODE_RLD_WR   - MODE_LSB;
  localparam int MODE_RLD_VBL  = LSPCMODE_RLD_VBL  - MODE_LSB;
  localparam int MODE_RLD_ZERO = LSPCMODE_RLD_ZERO - MODE_LSB;

  localparam int ACK_RST = 0;
  localparam int ACK_TMR = 1;
  localparam int ACK_VBL = 2;

  localparam logic [2:0] IRQ_LVL_NONE = 3'd0;
  localparam logic [2:0] IRQ_LVL_VBL  = 3'd1;
  localparam logic [2:0] IRQ_LVL_TMR  = 3'd2;
  localparam logic [2:0] IRQ_LVL_RST  = 3'd3;

  typedef struct packed {
    logic rst;
    logic tmr;
    logic vbl;
  } irq_pend_t;

  // Fixed priority: reset > timer > vblank
  function automatic logic [2:0] irq_prio(input irq_pend_t p);
    if (p.rst)      return IRQ_LVL_RST;
    else if (p.tmr) return IRQ_LVL_TMR;
    else if (p.vbl) return IRQ_LVL_VBL;
    else            return IRQ_LVL_NONE;
  endfunction

endpackage

// File: rtl/lspc_irq_pending.sv
// lspc_irq_pending: three set/acknowledge interrupt pending flops plus a
// registered priority encoder.
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset (RST pending comes up set)
//   i_set_tmr   timer expiry with timer IRQ enabled
//   i_set_vbl   VBlank start
//   i_ack       acknowledge strobe
//   i_ack_bits  DIN[2:0] of the ack write (RST, TMR, VBL)
//   o_pend      current pending bits
//   o_level     prioritised IRQ level, one cycle behind o_pend
module lspc_irq_pending
  import neo_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_set_tmr,
  input  logic       i_set_vbl,
  input  logic       i_ack,
  input  logic [2:0] i_ack_bits,
  output irq_pend_t  o_pend,
  output logic [2:0] o_level
);

  irq_pend_t  r_pend;
  logic [2:0] r_level;
  logic       w_clr_rst, w_clr_tmr, w_clr_vbl;

  assign w_clr_rst = i_ack & i_ack_bits[ACK_RST];
  assign w_clr_tmr = i_ack & i_ack_bits[ACK_TMR];
  assign w_clr_vbl = i_ack & i_ack_bits[ACK_VBL];

  // A set in the same cycle as its ack wins
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend  <= '{rst: 1'b1, tmr: 1'b0, vbl: 1'b0};
      r_level <= IRQ_LVL_RST;
    end else begin
      r_pend.rst <= r_pend.rst & ~w_clr_rst;
      r_pend.tmr <= i_set_tmr | (r_pend.tmr & ~w_clr_tmr);
      r_pend.vbl <= i_set_vbl | (r_pend.vbl & ~w_clr_vbl);
      r_level    <= irq_prio(r_pend);
    end
  end

  assign o_pend  = r_pend;
  assign o_level = r_level;

endmodule

// File: rtl/lspc_timer_irq.sv
// lspc_timer_irq: LSPC raster timer and 68k interrupt scheduler.
// A pixel-rate down-counter reloads from CPU writes, VBlank start or its
// own expiry; expiries and VBlank starts become latched interrupt requests.
//   CLK_24MB     system clock
//   RESETP       synchronous active-low reset
//   PIXEL_CE     one-cycle pixel enable (6 MHz)
//   BNK          vertical blanking level, rising edge = VBlank start
//   VMODE        1 = PAL, 0 = NTSC
//   DIN          CPU write data
//   WR_TIMER_HI  reload upper half write
//   WR_TIMER_LO  reload lower half write (optionally loads the counter)
//   WR_MODE      MODE <= DIN[7:4]
//   WR_STOP      STOP <= DIN[0]
//   WR_ACK       clear pending bits selected by DIN[2:0]
//   IRQ_LEVEL    highest pending level, 0 = none
//   TIMER_VAL    current counter value
//   TIMER_ZERO   one-cycle pulse on counter expiry
module lspc_timer_irq
  import neo_pkg::*;
#(
  parameter int TIMER_W     = 32,
  parameter int STOP_ON_BNK = 1
) (
  input  logic               CLK_24MB,
  input  logic               RESETP,
  input  logic               PIXEL_CE,
  input  logic               BNK,
  input  logic               VMODE,
  input  logic [15:0]        DIN,
  input  logic               WR_TIMER_HI,
  input  logic               WR_TIMER_LO,
  input  logic               WR_MODE,
  input  logic               WR_STOP,
  input  logic               WR_ACK,
  output logic [2:0]         IRQ_LEVEL,
  output logic [TIMER_W-1:0] TIMER_VAL,
  output logic               TIMER_ZERO
);

  logic [TIMER_W-1:0] r_counter, r_reload;
  logic [3:0]         r_mode;
  logic               r_stop, r_bnk_d, r_zero;

  logic [TIMER_W-1:0] w_lo_val, w_cnt_nxt;
  logic               w_bnk_rise, w_frozen, w_tick;
  logic               w_ld_wr, w_ld_vbl, w_expire;
  irq_pend_t          w_pend;

  // LO write loads the counter with the value being written this cycle
  assign w_lo_val   = {r_reload[TIMER_W-1:16], DIN};
  assign w_bnk_rise = BNK & ~r_bnk_d;
  // PAL blanking freeze: stops counting only, reloads still apply
  assign w_frozen   = (STOP_ON_BNK != 0) && r_stop && VMODE && BNK;
  assign w_tick     = PIXEL_CE & ~w_frozen;
  assign w_ld_wr    = WR_TIMER_LO & r_mode[MODE_RLD_WR];
  assign w_ld_vbl   = w_bnk_rise & r_mode[MODE_RLD_VBL];
  // Any reload this cycle pre-empts expiry
  assign w_expire   = w_tick & ~w_ld_wr & ~w_ld_vbl & (r_counter == '0);

  always_comb begin
    w_cnt_nxt = r_counter;
    if (w_ld_wr)
      w_cnt_nxt = w_lo_val;
    else if (w_ld_vbl)
      w_cnt_nxt = r_reload;
    else if (w_expire)
      w_cnt_nxt = r_mode[MODE_RLD_ZERO] ? r_reload : '1;
    else if (w_tick)
      w_cnt_nxt = r_counter - 1'b1;
  end

  always_ff @(posedge CLK_24MB) begin
    if (!RESETP) begin
      r_counter <= '0;
      r_reload  <= '0;
      r_mode    <= '0;
      r_stop    <= 1'b0;
      r_zero    <= 1'b0;
      r_bnk_d   <= BNK;
    end else begin
      r_counter <= w_cnt_nxt;
      r_zero    <= w_expire;
      r_bnk_d   <= BNK;
      if (WR_TIMER_HI) r_reload[TIMER_W-1:16] <= DIN[TIMER_W-17:0];
      if (WR_TIMER_LO) r_reload[15:0]         <= DIN;
      if (WR_MODE)     r_mode                 <= DIN[7:4];
      if (WR_STOP)     r_stop                 <= DIN[0];
    end
  end

  lspc_irq_pending u_pend (
    .i_clk      (CLK_24MB),
    .i_rst_n    (RESETP),
    .i_set_tmr  (w_expire & r_mode[MODE_TMR_EN]),
    .i_set_vbl  (w_bnk_rise),
    .i_ack      (WR_ACK),
    .i_ack_bits (DIN[2:0]),
    .o_pend     (w_pend),
    .o_level    (IRQ_LEVEL)
  );

  assign TIMER_VAL  = r_counter;
  assign TIMER_ZERO = r_zero;

endmodule

// File: tb/tb_lspc_timer_irq.sv
module tb_lspc_timer_irq;

  localparam logic [4:0] W_NONE = 5'b00000;
  localparam logic [4:0] W_HI   = 5'b10000;
  localparam logic [4:0] W_LO   = 5'b01000;
  localparam logic [4:0] W_MODE = 5'b00100;
  localparam logic [4:0] W_STOP = 5'b00010;
  localparam logic [4:0] W_ACK  = 5'b00001;

  logic        CLK_24MB = 1'b0;
  logic        RESETP = 1'b0, PIXEL_CE = 1'b0, BNK = 1'b0, VMODE = 1'b0;
  logic [15:0] DIN = '0;
  logic        WR_TIMER_HI = 0, WR_TIMER_LO = 0, WR_MODE = 0, WR_STOP = 0, WR_ACK = 0;
  logic [2:0]  IRQ_LEVEL;
  logic [31:0] TIMER_VAL;
  logic        TIMER_ZERO;

  always #5 CLK_24MB = ~CLK_24MB;

  lspc_timer_irq #(.TIMER_W(32), .STOP_ON_BNK(1)) dut (
    .CLK_24MB(CLK_24MB), .RESETP(RESETP), .PIXEL_CE(PIXEL_CE), .BNK(BNK),
    .VMODE(VMODE), .DIN(DIN), .WR_TIMER_HI(WR_TIMER_HI), .WR_TIMER_LO(WR_TIMER_LO),
    .WR_MODE(WR_MODE), .WR_STOP(WR_STOP), .WR_ACK(WR_ACK),
    .IRQ_LEVEL(IRQ_LEVEL), .TIMER_VAL(TIMER_VAL), .TIMER_ZERO(TIMER_ZERO)
  );

  typedef struct {
    logic        rst_n, pce, bnk, vmode;
    logic [4:0]  wr;
    logic [15:0] din;
    logic [2:0]  lvl;
    logic [31:0] val;
    logic        zero;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  lvl;
    logic [31:0] val;
    logic        zero;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst_n, input logic pce, input logic bnk, input logic vmode,
                     input logic [4:0] wr, input logic [15:0] din,
                     input logic [2:0] lvl, input logic [31:0] val, input logic zero);
    vec_t v;
    v.rst_n = rst_n; v.pce = pce; v.bnk = bnk; v.vmode = vmode;
    v.wr = wr; v.din = din; v.lvl = lvl; v.val = val; v.zero = zero;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RESETP = v.rst_n; PIXEL_CE = v.pce; BNK = v.bnk; VMODE = v.vmode; DIN = v.din;
    {WR_TIMER_HI, WR_TIMER_LO, WR_MODE, WR_STOP, WR_ACK} = v.wr;
  endtask

  initial begin
    exp_t e;
    int   ce_cnt;
    bit   seen;

    // ---- vector table: inputs and outputs expected after the clock edge ----
    //   rst pce bnk vm  wr      din       lvl  val           zero
    // reset, then ack the power-on request
    add(0, 0, 0, 0, W_NONE, 16'h0000, 3, 32'h0, 0);
    add(0, 0, 0, 0, W_NONE, 16'h0000, 3, 32'h0, 0);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 3, 32'h0, 0);
    add(1, 0, 0, 0, W_ACK,  16'h0001, 3, 32'h0, 0);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 0, 32'h0, 0);
    // load 4 via LO, expiry on 5th CE, wrap to all-ones
    add(1, 0, 0, 0, W_MODE, 16'h0030, 0, 32'h0, 0);
    add(1, 0, 0, 0, W_HI,   16'h0000, 0, 32'h0, 0);
    add(1, 0, 0, 0, W_LO,   16'h0004, 0, 32'h4, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h3, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h2, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h0, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'hFFFFFFFF, 1);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 2, 32'hFFFFFFFF, 0);
    add(1, 0, 0, 0, W_ACK,  16'h0002, 2, 32'hFFFFFFFF, 0);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 0, 32'hFFFFFFFF, 0);
    // auto-reload 2: expiry every 3 CEs, ack collides with an expiry
    add(1, 0, 0, 0, W_MODE, 16'h00B0, 0, 32'hFFFFFFFF, 0);
    add(1, 0, 0, 0, W_LO,   16'h0002, 0, 32'h2, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h0, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h2, 1);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h0, 0);
    add(1, 1, 0, 0, W_ACK,  16'h0002, 2, 32'h2, 1);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h0, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h2, 1);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h0, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 2, 32'h2, 1);
    add(1, 0, 0, 0, W_ACK,  16'h0002, 2, 32'h2, 0);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 0, 32'h2, 0);
    // VBlank reload; LO write without RLD_WR keeps counting
    add(1, 0, 0, 0, W_MODE, 16'h0040, 0, 32'h2, 0);
    add(1, 1, 0, 0, W_LO,   16'h0100, 0, 32'h1, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'h0, 0);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'hFFFFFFFF, 1);
    add(1, 1, 0, 0, W_NONE, 16'h0000, 0, 32'hFFFFFFFE, 0);
    add(1, 1, 1, 0, W_NONE, 16'h0000, 0, 32'h100, 0);
    add(1, 0, 1, 0, W_NONE, 16'h0000, 1, 32'h100, 0);
    add(1, 0, 0, 0, W_ACK,  16'h0004, 1, 32'h100, 0);
    add(1, 0, 0, 0, W_NONE, 16'h0000, 0, 32'h100, 0);
    // PAL freeze during blanking, then NTSC keeps counting
    add(1, 0, 0, 1, W_STOP, 16'h0001, 0, 32'h100, 0);
    add(1, 0, 1, 1, W_NONE, 16'h0000, 0, 32'h100, 0);
    for (int k = 1; k <= 10; k++) add(1, 1, 1, 1, W_NONE, 16'h0000, 1, 32'h100, 0);
    for (int k = 1; k <= 10; k++) add(1, 1, 1, 0, W_NONE, 16'h0000, 1, 32'h100 - k, 0);
    // BNK rise + LO load + would-be expiry in one cycle
    add(1, 0, 0, 0, W_ACK,  16'h0004, 1, 32'hF6, 0);
    add(1, 0, 0, 0, W_MODE, 16'h0070, 0, 32'hF6, 0);
    add(1, 0, 0, 0, W_LO,   16'h0000, 0, 32'h0, 0);
    add(1, 0, 0, 0, W_HI,   16'h1234, 0, 32'h0, 0);
    add(1, 1, 1, 0, W_LO,   16'hABCD, 0, 32'h1234ABCD, 0);
    add(1, 0, 1, 0, W_NONE, 16'h0000, 1, 32'h1234ABCD, 0);
    // reset with BNK high: no edge seen on the first cycle out of reset
    add(0, 0, 1, 0, W_NONE, 16'h0000, 3, 32'h0, 0);
    add(1, 0, 1, 0, W_ACK,  16'h0001, 3, 32'h0, 0);
    add(1, 0, 1, 0, W_NONE, 16'h0000, 0, 32'h0, 0);

    // ---- apply table; expectations go through the scoreboard ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      e.idx = i; e.lvl = vecs[i].lvl; e.val = vecs[i].val; e.zero = vecs[i].zero;
      sb.push_back(e);
      @(posedge CLK_24MB); #1;
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_empty vec %0d: got 0 entries want 1", i);
      end else begin
        e = sb.pop_front();
        chk("irq_level",  e.idx, {29'd0, IRQ_LEVEL}, {29'd0, e.lvl});
        chk("timer_val",  e.idx, TIMER_VAL,          e.val);
        chk("timer_zero", e.idx, {31'd0, TIMER_ZERO}, {31'd0, e.zero});
      end
    end

    // ---- hand sequence: expiry latency from reload 7 is 8 counted CEs ----
    BNK = 0; PIXEL_CE = 0; VMODE = 0;
    {WR_TIMER_HI, WR_TIMER_LO, WR_MODE, WR_STOP, WR_ACK} = W_MODE; DIN = 16'h0030;
    @(posedge CLK_24MB); #1;
    {WR_TIMER_HI, WR_TIMER_LO, WR_MODE, WR_STOP, WR_ACK} = W_LO; DIN = 16'h0007;
    @(posedge CLK_24MB); #1;
    {WR_TIMER_HI, WR_TIMER_LO, WR_MODE, WR_STOP, WR_ACK} = W_NONE; DIN = '0;
    chk("latency_load", -1, TIMER_VAL, 32'h7);
    ce_cnt = 0; seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      PIXEL_CE = 1;
      @(posedge CLK_24MB); #1;
      ce_cnt++;
      if (TIMER_ZERO) seen = 1;
    end
    PIXEL_CE = 0;
    if (!seen) begin
      errors++; checks++;
      $display("FAIL latency_timeout: got no TIMER_ZERO in 20 CEs want one at CE 8");
    end else begin
      chk("latency_ces", -1, ce_cnt, 32'd8);
      chk("latency_wrap", -1, TIMER_VAL, 32'hFFFFFFFF);
    end
    @(posedge CLK_24MB); #1;
    chk("latency_level", -1, {29'd0, IRQ_LEVEL}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lspc_timer_irq.md
Name: lspc_timer_irq

Overview:
- Raster timer and interrupt scheduler for the LSPC video block.
- Sequences a 32-bit pixel-rate down-counter against the video sync outputs: pixel clock enable, BNK and VMODE.
- Latches VBlank, timer and power-on-reset interrupt requests, and presents a prioritised 68k IRQ level.
- Sits between the 68k register decode (timer, mode and ack writes) and the CPU interrupt inputs.

Parameters:
- TIMER_W, 32, width of the timer counter and reload register (upper half written via HI, lower via LO).
- STOP_ON_BNK, 1, enables the PAL blanking freeze feature (0 = stop bit ignored).

Ports:
- CLK_24MB  in  1  system clock; all state updates on rising edge.
- RESETP  in  1  active-low reset, synchronous to CLK_24MB.
- PIXEL_CE  in  1  one-CLK_24MB-cycle enable per 6 MHz pixel.
- BNK  in  1  vertical blanking level from video sync; rising edge = VBlank start.
- VMODE  in  1  1 = PAL, 0 = NTSC.
- DIN  in  16  CPU write data.
- WR_TIMER_HI  in  1  one-cycle strobe: RELOAD[31:16] <= DIN.
- WR_TIMER_LO  in  1  one-cycle strobe: RELOAD[15:0] <= DIN.
- WR_MODE  in  1  one-cycle strobe: MODE <= DIN[7:4].
- WR_STOP  in  1  one-cycle strobe: STOP <= DIN[0].
- WR_ACK  in  1  one-cycle strobe: clear pending bits where DIN[2:0]=1.
- IRQ_LEVEL  out  3  highest pending enabled level, 0 = none.
- TIMER_VAL  out  TIMER_W  current counter, for debug.
- TIMER_ZERO  out  1  one-cycle pulse when the counter expires.

Behaviour:
- Reset (RESETP=0 at a clock edge):
  - COUNTER = 0, RELOAD = 0, MODE = 0, STOP = 0.
  - Pending: VBL = 0, TMR = 0, RST = 1.
  - Outputs: IRQ_LEVEL = 3, TIMER_ZERO = 0.
  - BNK edge detector register <= current BNK, so no edge is detected on the first cycle after reset.
- MODE bits:
  - MODE[0] (DIN4) = timer IRQ enable.
  - MODE[1] (DIN5) = reload on LO write.
  - MODE[2] (DIN6) = reload at VBlank start.
  - MODE[3] (DIN7) = reload on expiry.
- Frozen condition: STOP_ON_BNK & STOP & VMODE & BNK. While frozen, PIXEL_CE is ignored for counting.
- Counter update priority, evaluated per clock, highest first:
  1. WR_TIMER_LO & MODE[1]: COUNTER <= {RELOAD[31:16], DIN}. The just-written value is used in the same cycle.
  2. BNK rising edge & MODE[2]: COUNTER <= RELOAD.
  3. PIXEL_CE & !frozen & COUNTER==0:
     - TIMER_ZERO = 1.
     - TMR pending set if MODE[0].
     - COUNTER <= MODE[3] ? RELOAD : all-ones (wrap).
  4. PIXEL_CE & !frozen & COUNTER!=0: COUNTER <= COUNTER-1.
- Expiry latency: from a reload value N (loaded with no further reloads), expiry occurs on the (N+1)th counted PIXEL_CE.
- VBL pending is set on every BNK rising edge, independent of MODE.
- Acknowledge:
  - WR_ACK clears bits: DIN0 -> RST, DIN1 -> TMR, DIN2 -> VBL.
  - A set event in the same cycle as its ack wins; the bit stays set.
- IRQ_LEVEL is registered from the pending bits, one cycle after they change:
  - RST -> 3, else TMR -> 2, else VBL -> 1, else 0.
- Writes to HI, MODE and STOP do not disturb the counter. A MODE write takes effect on the next clock.
- Simultaneous WR_TIMER_LO with MODE[1]=0: only RELOAD is updated; counting continues normally.

Decomposition:
- Shared package neo_pkg holds:
  - Constants LSPCMODE_TMR_EN=4, LSPCMODE_RLD_WR=5, LSPCMODE_RLD_VBL=6, LSPCMODE_RLD_ZERO=7.
  - Ack bit indices ACK_RST=0, ACK_TMR=1, ACK_VBL=2.
  - Level constants IRQ_LVL_VBL=1, IRQ_LVL_TMR=2, IRQ_LVL_RST=3.
- One natural sub-module: lspc_irq_pending. It holds the three set/ack pending flops and the registered priority encoder. The counter logic stays in the top level.

Test Plan:
- Reset, then WR_ACK DIN=0x0001 -> IRQ_LEVEL 3 after reset, then 0 two cycles after the ack.
- MODE=0x30, HI=0x0000, LO=0x0004, then 5 PIXEL_CE -> TIMER_ZERO on the 5th CE; IRQ_LEVEL=2 next cycle; counter wraps to 0xFFFFFFFF.
- MODE=0xB0, LO=0x0002 -> expiry every 3 CEs, repeated 4 times. Ack with DIN=0x0002 on the same cycle as an expiry -> TMR stays pending.
- MODE=0x40, RELOAD=0x100, counter mid-count; BNK rises -> COUNTER=0x100 next cycle; VBL pending, IRQ_LEVEL=1.
- VMODE=1, STOP=1, BNK=1, 10 PIXEL_CE -> counter unchanged. Same with VMODE=0 -> counter decrements by 10.
- BNK rise, LO write with MODE[1] and expiry all in one cycle -> counter = {HI, DIN}; no TIMER_ZERO; VBL set.
